// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong paddle input path.
// Holds the per-button debounce state encoding and the default timing constants.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT1   = 2'd1,
        PRESSED = 2'd2,
        WAIT0   = 2'd3
    } db_state_e;

    // 10 ms debounce and 50 ms auto-repeat at 100 MHz.
    localparam int DB_CYCLES_DEF     = 1_000_000;
    localparam int REPEAT_CYCLES_DEF = 5_000_000;

    // The debounce counter is shared between the debounce and repeat intervals.
    function automatic int cnt_width(input int db_cycles, input int repeat_cycles);
        int max_cycles;
        max_cycles = (db_cycles > repeat_cycles) ? db_cycles : repeat_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer feeding a four-state debounce FSM.
// Define PADDLE_BTN_REPEAT_EN to emit repeat ticks every REPEAT_CYCLES while held.
module btn_debounce_ch
    import pong_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic btn_db_o,
    output logic btn_tick_o
);

    localparam int               CNT_W   = cnt_width(DB_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef PADDLE_BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_TERM = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic             sync1_q, sync2_q;
    logic             s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             db_q, db_d;
    logic             tick_q, tick_d;
`ifdef PADDLE_BTN_REPEAT_EN
    logic             rep_fire_q, rep_fire_d;
`endif

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign s       = sync2_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef PADDLE_BTN_REPEAT_EN
        rep_fire_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_TERM) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
`ifdef PADDLE_BTN_REPEAT_EN
                else if (cnt_q == REP_TERM) begin
                    cnt_d      = '0;
                    rep_fire_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            WAIT0: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_TERM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // db_q still holds the previous state's level, so PRESSED with db_q low means we came from WAIT1.
    always_comb begin
        db_d   = (state_q == PRESSED) || (state_q == WAIT0);
        tick_d = (state_q == PRESSED) && !db_q;
`ifdef PADDLE_BTN_REPEAT_EN
        tick_d = tick_d || rep_fire_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            tick_q  <= tick_d;
        end
    end

`ifdef PADDLE_BTN_REPEAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_fire_q <= 1'b0;
        end else begin
            rep_fire_q <= rep_fire_d;
        end
    end
`endif

    assign btn_db_o   = db_q;
    assign btn_tick_o = tick_q;

endmodule

// File: rtl/paddle_btn_conditioner.sv
// Conditions the two raw paddle buttons ([1]=up, [0]=down) into debounced levels and press ticks.
// Define PADDLE_BTN_REPEAT_EN to enable auto-repeat ticks while a button is held.
module paddle_btn_conditioner
    import pong_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn_db,
    output logic [1:0] btn_tick
);

    // Buttons are fully independent; simultaneous presses tick together.
    for (genvar i = 0; i < 2; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_raw_i  (btn_raw[i]),
            .btn_db_o   (btn_db[i]),
            .btn_tick_o (btn_tick[i])
        );
    end

endmodule

// File: tb/tb_paddle_btn_conditioner.sv
// Self-checking bench for paddle_btn_conditioner (DB_CYCLES=4, REPEAT_CYCLES=6).
// Directed latency/glitch/reset steps plus random button traffic against a run-length model.
module tb_paddle_btn_conditioner;

    localparam int DB  = 4;
    localparam int REP = 6;
`ifdef PADDLE_BTN_REPEAT_EN
    localparam logic [1:0] REP_TICK = 2'b01;
`else
    localparam logic [1:0] REP_TICK = 2'b00;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] btn_raw;
    logic [1:0] btn_db;
    logic [1:0] btn_tick;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: accepted level flips after DB+1 consecutive opposite synchronized samples.
    logic [1:0] hist[$];
    logic [1:0] m_lvl;
    logic [1:0] m_evt;
    int         m_run[2];
    int         m_streak[2];

    paddle_btn_conditioner #(
        .DB_CYCLES     (DB),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_db   (btn_db),
        .btn_tick (btn_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_lvl = 2'b00;
        m_evt = 2'b00;
        for (int b = 0; b < 2; b++) begin
            m_run[b]    = 0;
            m_streak[b] = 0;
        end
    endtask

    // Called at posedge+1; drives raw, advances one edge and compares against the model.
    task automatic step(input logic [1:0] raw);
        logic [1:0] s, exp_db, exp_tick;
        btn_raw = raw;
        @(posedge clk);
        hist.push_back(raw);
        s = (hist.size() >= 3) ? hist[hist.size() - 3] : 2'b00;
        #1;
        exp_db   = m_lvl;
        exp_tick = m_evt;
        for (int b = 0; b < 2; b++) begin
            m_evt[b] = 1'b0;
            if (s[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DB + 1) begin
                    m_lvl[b]    = s[b];
                    m_run[b]    = 0;
                    m_streak[b] = 0;
                    m_evt[b]    = s[b];
                end
            end else if (m_run[b] != 0) begin
                m_run[b]    = 0;
                m_streak[b] = 0;
            end else if (m_lvl[b]) begin
                m_streak[b]++;
`ifdef PADDLE_BTN_REPEAT_EN
                if (m_streak[b] % REP == 0) m_evt[b] = 1'b1;
`endif
            end
        end
        check("model_db", btn_db, exp_db);
        check("model_tick", btn_tick, exp_tick);
    endtask

    // Asynchronous reset pulse: outputs must clear without a clock edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_db", btn_db, 2'b00);
        check("rst_tick", btn_tick, 2'b00);
        model_reset();
        @(posedge clk);
        #4;
        rst = 1'b1;
    endtask

    initial begin
        logic [1:0] cur;
        int         hold[2];

        rst     = 1'b1;
        btn_raw = 2'b00;
        model_reset();
        #2;
        do_reset();

        // Single press on bit 0: level and tick after edge 7, tick gone after edge 8.
        for (int e = 0; e < 12; e++) begin
            step(2'b01);
            if (e == 6) check("r026_db_e6", btn_db, 2'b00);
            if (e == 7) begin
                check("r026_db_e7", btn_db, 2'b01);
                check("r026_tick_e7", btn_tick, 2'b01);
            end
            if (e == 8) check("r026_tick_e8", btn_tick, 2'b00);
        end

        // Short release glitch while pressed keeps the level.
        for (int e = 0; e < 10; e++) begin
            step((e < 2) ? 2'b00 : 2'b01);
            check("r028_glitch_db", btn_db, 2'b01);
        end

        // Real release: level drops after edge 7.
        for (int e = 0; e < 11; e++) begin
            step(2'b00);
            if (e == 6) check("r028_rel_e6", btn_db, 2'b01);
            if (e == 7) check("r028_rel_e7", btn_db, 2'b00);
        end

        // 3-cycle pulse on bit 1 is rejected.
        for (int e = 0; e < 12; e++) begin
            step((e < 3) ? 2'b10 : 2'b00);
            check("r027_db", btn_db, 2'b00);
            check("r027_tick", btn_tick, 2'b00);
        end

        // Simultaneous presses.
        for (int e = 0; e < 10; e++) begin
            step(2'b11);
            if (e == 7) begin
                check("r029_db", btn_db, 2'b11);
                check("r029_tick", btn_tick, 2'b11);
            end
        end

        // Reset while both held, then a press aborted by reset at edge 5.
        do_reset();
        for (int e = 0; e < 6; e++) step(2'b01);
        do_reset();
        for (int e = 0; e < 22; e++) begin
            step(2'b01);
            if (e == 6) check("r030_db_e6", btn_db, 2'b00);
            if (e == 7) begin
                check("r030_db_e7", btn_db, 2'b01);
                check("r030_tick_e7", btn_tick, 2'b01);
            end
            if (e == 8 || e == 12) check("r030_tick_gap", btn_tick, 2'b00);
            if (e == 13 || e == 19) check("r030_rep", btn_tick, REP_TICK);
        end

        // Random traffic mixing glitches and stable holds, with one reset midway.
        cur     = btn_raw;
        hold[0] = 0;
        hold[1] = 0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            for (int b = 0; b < 2; b++) begin
                if (hold[b] == 0) begin
                    cur[b]  = ~cur[b];
                    hold[b] = int'($urandom_range(12, 1));
                end
                hold[b]--;
            end
            step(cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/paddle_btn_conditioner.md
PADDLE_BTN_CONDITIONER -- requirements
Module: paddle_btn_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, stable-input cycles required to accept a level change (10 ms at 100 MHz); legal range >= 1.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 5000000, auto-repeat period in cycles; legal range >= 1; used only when PADDLE_BTN_REPEAT_EN is defined.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_raw  input  2  raw asynchronous paddle buttons, [1]=up, [0]=down, active-high.
REQ-006 SHALL have port btn_db  output  2  debounced button levels; this is the btn[1:0] input of the animated Pong top.
REQ-007 SHALL have port btn_tick  output  2  one-cycle press pulse per button.

Function
REQ-008 SHALL pass each btn_raw bit through a 2-flop synchronizer; FSM input s = second flop.
REQ-009 SHALL run one independent FSM per bit with states IDLE, WAIT1, PRESSED, WAIT0 and a counter cnt of width clog2(max(DB_CYCLES, REPEAT_CYCLES)+1).
REQ-010 IDLE: s=1 -> WAIT1, cnt<=0; else stay.
REQ-011 WAIT1: s=0 -> IDLE; s=1 and cnt==DB_CYCLES-1 -> PRESSED, cnt<=0; else cnt<=cnt+1.
REQ-012 PRESSED: s=0 -> WAIT0, cnt<=0; else stay.
REQ-013 WAIT0: s=1 -> PRESSED; s=0 and cnt==DB_CYCLES-1 -> IDLE; else cnt<=cnt+1.
REQ-014 btn_db SHALL be registered, high exactly in PRESSED and WAIT0.
REQ-015 btn_tick SHALL be registered, high for exactly one cycle on the edge entering PRESSED from WAIT1; WAIT0->PRESSED SHALL NOT pulse.
REQ-016 Latency: btn_raw held high from edge 0 -> btn_db and btn_tick high after edge DB_CYCLES+3; release latency identical.
REQ-017 Any glitch shorter than DB_CYCLES consecutive synchronized cycles SHALL NOT change btn_db.
REQ-018 Both buttons SHALL be processed independently; simultaneous presses SHALL give btn_db=2'b11 and simultaneous ticks; no arbitration.
REQ-019 Counter SHALL never wrap; it is cleared on every state entry and saturates at its terminal value.

Reset
REQ-020 rst low SHALL asynchronously force synchronizer flops=0, all FSMs=IDLE, cnt=0, btn_db=2'b00, btn_tick=2'b00.
REQ-021 Reset asserted mid-debounce or mid-press SHALL abort it with no tick; a button held across reset release SHALL be seen as a new press, btn_db high after edge DB_CYCLES+3 counted from the first edge after release.

Configuration
REQ-022 With PADDLE_BTN_REPEAT_EN defined: in PRESSED with s=1, cnt SHALL count, and btn_tick SHALL pulse again every REPEAT_CYCLES cycles after the initial tick while held; WAIT0 SHALL stop repeats.
REQ-023 With PADDLE_BTN_REPEAT_EN undefined: exactly one tick per accepted press; no repeat logic or REPEAT_CYCLES comparator SHALL be synthesized.

Structure
REQ-024 Package pong_pkg SHALL hold the debounce state enum (IDLE, WAIT1, PRESSED, WAIT0) and default constants DB_CYCLES_DEF and REPEAT_CYCLES_DEF.
REQ-025 The synchronizer and FSM SHALL be one sub-module btn_debounce_ch (1-bit), instantiated twice via generate.

Verification (DB_CYCLES=4, REPEAT_CYCLES=6)
REQ-026 btn_raw=01 held from edge 0 -> btn_db=01 and btn_tick=01 after edge 7; btn_tick=00 after edge 8; btn_db stays 01.
REQ-027 btn_raw[1] high for 3 cycles, then low -> btn_db[1] and btn_tick[1] stay 0 throughout.
REQ-028 pressed state, btn_raw low 2 cycles then high -> btn_db stays 1, no tick; held low 4+ cycles -> btn_db=0 after edge 7 relative to falling input.
REQ-029 btn_raw=11 from edge 0 -> btn_db=11, btn_tick=11 together after edge 7.
REQ-030 rst low at edge 5 of a press -> outputs 00 immediately; release with button held -> btn_db high after edge 7 post-release; with PADDLE_BTN_REPEAT_EN, holding -> ticks at edges 7, 13, 19.
